// File: rtl/bcd_operand_loader_pkg.sv
// bcd_operand_loader_pkg: shared FSM states, default sizes and the seven-segment digit table
package bcd_operand_loader_pkg;
  localparam int DIGITS_DEF = 3;
  localparam int MAG_W_DEF = 10;
  localparam int BIN_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;
  // gfedcba, digit 0..9, shared with the display path
  localparam logic [6:0] SEG7 [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
endpackage

// File: rtl/bcd_operand_loader_nibble_fix.sv
// bcd_nibble_fix: reverse double-dabble correction, subtract 3 from a nibble of 8 or more
module bcd_nibble_fix (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd8 ? d - 4'd3 : d;
endmodule

// File: rtl/bcd_operand_loader.sv
// bcd_operand_loader: sequential BCD-to-binary converter with sign and signed saturation
module bcd_operand_loader
  import bcd_operand_loader_pkg::*;
#(
  parameter int DIGITS = DIGITS_DEF,
  parameter int MAG_W = MAG_W_DEF,
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                neg,
  input  logic [4*DIGITS-1:0] bcd_in,
  output logic                busy,
  output logic                done,
  output logic [BIN_W-1:0]    bin_out,
  output logic                ovf,
  output logic                bad_digit
);
  localparam int W = 4 * DIGITS + MAG_W;
  localparam int CW = $clog2(MAG_W);
  localparam logic [CW-1:0] LAST = CW'(MAG_W - 1);
  localparam logic [MAG_W-1:0] POS_MAX = MAG_W'(2 ** (BIN_W - 1) - 1);
  localparam logic [MAG_W-1:0] NEG_MAX = MAG_W'(2 ** (BIN_W - 1));
  localparam logic [BIN_W-1:0] SAT_P = {1'b0, {(BIN_W - 1){1'b1}}};
  localparam logic [BIN_W-1:0] SAT_N = {1'b1, {(BIN_W - 1){1'b0}}};
  state_t state_q, state_d;
  logic [W-1:0] work_q, work_d, shifted;
  logic [CW-1:0] count_q, count_d;
  logic neg_q, neg_d, bad_q, bad_d, done_q, done_d, ovf_q, ovf_d, badd_q, badd_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [4*DIGITS-1:0] fixed_bcd;
  logic [DIGITS-1:0] bad_vec;
  logic [MAG_W-1:0] mag;
  logic [BIN_W-1:0] mag_lo;
  assign shifted = work_q >> 1;
  assign mag = work_q[MAG_W-1:0];
  assign mag_lo = mag[BIN_W-1:0];
  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bcd_nibble_fix u_fix (.d(shifted[MAG_W+4*i +: 4]), .q(fixed_bcd[4*i +: 4]));
    assign bad_vec[i] = bcd_in[4*i +: 4] > 4'd9;
  end
  always_comb begin
    state_d = state_q;
    work_d = work_q;
    count_d = count_q;
    neg_d = neg_q;
    bad_d = bad_q;
    done_d = 1'b0;
    bin_d = bin_q;
    ovf_d = ovf_q;
    badd_d = badd_q;
    case (state_q)
      IDLE: if (start) begin
        work_d = {bcd_in, MAG_W'(0)};
        neg_d = neg;
        bad_d = |bad_vec;
        count_d = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        work_d = {fixed_bcd, shifted[MAG_W-1:0]};
        count_d = count_q + 1'b1;
        state_d = count_q == LAST ? FINISH : SHIFT;
      end
      FINISH: begin
        done_d = 1'b1;
        state_d = IDLE;
        badd_d = bad_q;
        ovf_d = !bad_q && (neg_q ? mag > NEG_MAX : mag > POS_MAX);
        bin_d = bad_q ? '0 : ovf_d ? (neg_q ? SAT_N : SAT_P) : neg_q ? -mag_lo : mag_lo;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      count_q <= '0;
      neg_q <= 1'b0;
      bad_q <= 1'b0;
      done_q <= 1'b0;
      bin_q <= '0;
      ovf_q <= 1'b0;
      badd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q <= work_d;
      count_q <= count_d;
      neg_q <= neg_d;
      bad_q <= bad_d;
      done_q <= done_d;
      bin_q <= bin_d;
      ovf_q <= ovf_d;
      badd_q <= badd_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = done_q;
  assign bin_out = bin_q;
  assign ovf = ovf_q;
  assign bad_digit = badd_q;
endmodule
